intersection_ctrl: RTL and testbench
====================================

INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 Parameter GREEN_CYC, default 8: green phase length, clock cycles, >=1.
REQ-002 Parameter YELLOW_CYC, default 3: yellow phase length, cycles, >=1.
REQ-003 Parameter ALLRED_CYC, default 2: all-red clearance length, cycles, >=1.
REQ-004 Parameter WALK_CYC, default 5: pedestrian walk length, cycles, >=1.
REQ-005 Parameter CNT_W, default 8: timer width; every *_CYC SHALL be <= 2**CNT_W.
REQ-006 clk  input  1  single clock, rising edge.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  run enable; low freezes state and timer.
REQ-009 ped_req  input  1  pedestrian request, single-cycle or level.
REQ-010 ns_r, ns_y, ns_g  output  1 each  north-south lamps.
REQ-011 ew_r, ew_y, ew_g  output  1 each  east-west lamps.
REQ-012 walk  output  1  pedestrian walk lamp.
REQ-013 phase  output  3  current state encoding.
REQ-014 ped_pending  output  1  latched, unserved pedestrian request.

Function
REQ-015 States SHALL be IDLE, NS_G, NS_Y, AR1, EW_G, EW_Y, AR2 and WALK.
REQ-016 Lamp outputs SHALL be a Moore decode of the state register: exactly one of r/y/g per direction high; red in every state except the direction's own G/Y.
REQ-017 walk SHALL be 1 only in WALK; both directions SHALL be red in IDLE, AR1, AR2 and WALK.
REQ-018 IDLE -> NS_G on the first clk edge with start=1.
REQ-019 Each timed state SHALL last exactly its *_CYC count of clk edges sampled with start=1, then advance.
REQ-020 Sequence: NS_G -> NS_Y -> AR1 -> EW_G -> EW_Y -> AR2 -> (WALK if ped_pending, else NS_G); WALK -> NS_G.
REQ-021 Timer SHALL load *_CYC-1 on state entry, decrement on start=1, and advance state at zero; with *_CYC=1 the state SHALL last one enabled cycle.
REQ-022 While start=0, state, timer and lamps SHALL hold; no phase SHALL be skipped or shortened.
REQ-023 ped_pending SHALL be set on the edge after ped_req=1 and cleared on entry to WALK.
REQ-024 ped_req=1 on the AR2->WALK edge SHALL NOT re-set ped_pending; ped_req during WALK SHALL be ignored.
REQ-025 ped_req SHALL be sampled regardless of start.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, timer 0 and ped_pending 0, from any state including mid-phase.
REQ-027 Reset outputs: ns_r=ew_r=1, all y/g=0, walk=0, phase=IDLE, ped_pending=0.
REQ-028 After rst_n deassertion, behaviour SHALL be per REQ-018.

Structure
REQ-029 State encoding enum and default durations SHALL be in package intersection_pkg.
REQ-030 The down-counter SHALL be sub-module phase_timer (load, enable, value, zero flag), width CNT_W.
REQ-031 All state-holding elements SHALL be asynchronously reset flops on clk; no latches.

Verification
REQ-032 Defaults, start=1 from reset, no ped_req -> NS_G 8, NS_Y 3, AR1 2, EW_G 8, EW_Y 3, AR2 2 cycles, then NS_G; 26-cycle period.
REQ-033 One-cycle ped_req during EW_G -> ped_pending=1, WALK for 5 cycles after AR2, ped_pending=0 on WALK entry, then NS_G.
REQ-034 start=0 for 4 cycles during NS_Y cycle 2 -> NS_Y total still 3 enabled cycles, lamps frozen.
REQ-035 rst_n=0 mid-EW_G -> immediate all-red, IDLE, ped_pending=0; restart begins at NS_G.
REQ-036 GREEN_CYC=YELLOW_CYC=ALLRED_CYC=WALK_CYC=1 -> each state 1 cycle, period 6, WALK inserted when requested.
REQ-037 Every cycle checker: never green/yellow on both directions; walk=1 only with both red.

Source files
------------

// File: rtl/intersection_pkg.sv
// Shared state encoding and default phase durations for the intersection controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package intersection_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NS_G = 3'd1,
    NS_Y = 3'd2,
    AR1  = 3'd3,
    EW_G = 3'd4,
    EW_Y = 3'd5,
    AR2  = 3'd6,
    WALK = 3'd7
  } state_e;

  localparam int DEF_GREEN_CYC  = 8;
  localparam int DEF_YELLOW_CYC = 3;
  localparam int DEF_ALLRED_CYC = 2;
  localparam int DEF_WALK_CYC   = 5;
  localparam int DEF_CNT_W      = 8;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one phase; zero flags the last cycle of the phase.
// Latency: load/decrement visible one clk after the request.
// Backpressure: en=0 holds the value; load has priority over en.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] value_q;
  logic [CNT_W-1:0] value_d;

  // Next count: load wins, otherwise decrement while enabled and not yet at zero.
  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (en && (value_q != '0)) begin
      value_d = value_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign zero  = (value_q == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-way traffic light sequencer with a latched pedestrian walk phase.
// Latency: lamps are a Moore decode of the state register (change one clk after the deciding edge).
// Backpressure: start=0 freezes state, timer and lamps; ped_req is latched regardless of start.
module intersection_ctrl
  import intersection_pkg::*;
#(
  parameter int GREEN_CYC  = DEF_GREEN_CYC,
  parameter int YELLOW_CYC = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC = DEF_ALLRED_CYC,
  parameter int WALK_CYC   = DEF_WALK_CYC,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       ped_req,
  output logic       ns_r,
  output logic       ns_y,
  output logic       ns_g,
  output logic       ew_r,
  output logic       ew_y,
  output logic       ew_g,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  // Timer holds cycles remaining after the current one, hence the -1.
  localparam logic [CNT_W-1:0] GREEN_LD  = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] YELLOW_LD = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] ALLRED_LD = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] WALK_LD   = CNT_W'(WALK_CYC - 1);

  state_e           state_q;
  state_e           state_d;
  logic             ped_pending_q;
  logic             ped_pending_d;
  logic             adv;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_en;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_zero;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .value    (tmr_value),
    .zero     (tmr_zero)
  );

  // Next state, timer control and pedestrian latch.
  always_comb begin
    state_d       = state_q;
    ped_pending_d = ped_pending_q;
    tmr_val       = '0;
    adv           = start && ((state_q == IDLE) || tmr_zero);

    if (adv) begin
      case (state_q)
        IDLE:    state_d = NS_G;
        NS_G:    state_d = NS_Y;
        NS_Y:    state_d = AR1;
        AR1:     state_d = EW_G;
        EW_G:    state_d = EW_Y;
        EW_Y:    state_d = AR2;
        AR2:     state_d = ped_pending_q ? WALK : NS_G;
        WALK:    state_d = NS_G;
        default: state_d = IDLE;
      endcase
    end

    case (state_d)
      NS_G, EW_G: tmr_val = GREEN_LD;
      NS_Y, EW_Y: tmr_val = YELLOW_LD;
      AR1, AR2:   tmr_val = ALLRED_LD;
      WALK:       tmr_val = WALK_LD;
      default:    tmr_val = '0;
    endcase

    tmr_load = adv;
    tmr_en   = start && !adv;

    // Entering WALK serves the request; a request on that same edge is absorbed by it.
    if (adv && (state_d == WALK)) begin
      ped_pending_d = 1'b0;
    end else if (ped_req && (state_q != WALK)) begin
      ped_pending_d = 1'b1;
    end
  end

  // State and pedestrian latch registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ped_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ped_pending_q <= ped_pending_d;
    end
  end

  // Moore lamp decode: each direction is red unless in its own green/yellow.
  always_comb begin
    ns_g = (state_q == NS_G);
    ns_y = (state_q == NS_Y);
    ns_r = !(ns_g || ns_y);
    ew_g = (state_q == EW_G);
    ew_y = (state_q == EW_Y);
    ew_r = !(ew_g || ew_y);
    walk = (state_q == WALK);
  end

  assign phase       = state_q;
  assign ped_pending = ped_pending_q;

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;
  import intersection_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic ped_req = 1'b0;

  logic [1:0] ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, pend;
  logic [2:0] phase [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intersection_ctrl u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .ped_req(ped_req),
    .ns_r(ns_r[0]), .ns_y(ns_y[0]), .ns_g(ns_g[0]),
    .ew_r(ew_r[0]), .ew_y(ew_y[0]), .ew_g(ew_g[0]),
    .walk(walk[0]), .phase(phase[0]), .ped_pending(pend[0])
  );

  intersection_ctrl #(
    .GREEN_CYC(1), .YELLOW_CYC(1), .ALLRED_CYC(1), .WALK_CYC(1), .CNT_W(8)
  ) u_one (
    .clk(clk), .rst_n(rst_n), .start(start), .ped_req(ped_req),
    .ns_r(ns_r[1]), .ns_y(ns_y[1]), .ns_g(ns_g[1]),
    .ew_r(ew_r[1]), .ew_y(ew_y[1]), .ew_g(ew_g[1]),
    .walk(walk[1]), .phase(phase[1]), .ped_pending(pend[1])
  );

  // Reference model, one slot per instance: state, enabled cycles elapsed in state, pending latch.
  state_e m_state [2];
  int     m_el    [2];
  logic   m_pend  [2];

  typedef struct {
    int         inst;
    logic [2:0] ph;
    logic       pnd;
  } exp_t;
  exp_t sb[$];

  function automatic int dur(input int i, input state_e s);
    if (i == 1) return 1;
    case (s)
      NS_G, EW_G: return 8;
      NS_Y, EW_Y: return 3;
      AR1, AR2:   return 2;
      WALK:       return 5;
      default:    return 1;
    endcase
  endfunction

  function automatic state_e nxt(input state_e s, input logic p);
    case (s)
      IDLE:    return NS_G;
      NS_G:    return NS_Y;
      NS_Y:    return AR1;
      AR1:     return EW_G;
      EW_G:    return EW_Y;
      EW_Y:    return AR2;
      AR2:     return p ? WALK : NS_G;
      default: return NS_G;
    endcase
  endfunction

  // {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk}
  function automatic logic [6:0] lamps_of(input logic [2:0] ph);
    case (ph)
      3'd1:    return 7'b001_100_0;
      3'd2:    return 7'b010_100_0;
      3'd4:    return 7'b100_001_0;
      3'd5:    return 7'b100_010_0;
      3'd7:    return 7'b100_100_1;
      default: return 7'b100_100_0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_state[i] = IDLE;
      m_el[i]    = 0;
      m_pend[i]  = 1'b0;
    end
  endtask

  task automatic model_step(input int i, input logic st, input logic pr);
    logic   adv;
    logic   entering_walk;
    state_e s;
    s   = m_state[i];
    adv = st && ((s == IDLE) || (m_el[i] + 1 >= dur(i, s)));
    entering_walk = adv && (s == AR2) && m_pend[i];
    if (adv) begin
      m_state[i] = nxt(s, m_pend[i]);
      m_el[i]    = 0;
    end else if (st) begin
      m_el[i] = m_el[i] + 1;
    end
    if (entering_walk) m_pend[i] = 1'b0;
    else if (pr && (s != WALK)) m_pend[i] = 1'b1;
  endtask

  task automatic check_inst(input exp_t e);
    int i;
    logic [6:0] obs_l;
    i = e.inst;
    obs_l = {ns_r[i], ns_y[i], ns_g[i], ew_r[i], ew_y[i], ew_g[i], walk[i]};
    chk($sformatf("phase[%0d]", i), 32'(phase[i]), 32'(e.ph));
    chk($sformatf("lamps[%0d]", i), 32'(obs_l), 32'(lamps_of(e.ph)));
    chk($sformatf("ped_pending[%0d]", i), 32'(pend[i]), 32'(e.pnd));
    chk($sformatf("safe_conflict[%0d]", i),
        32'((ns_g[i] | ns_y[i]) & (ew_g[i] | ew_y[i])), 32'd0);
    chk($sformatf("safe_walk[%0d]", i),
        32'(walk[i] & ~(ns_r[i] & ew_r[i])), 32'd0);
  endtask

  // One clock: drive inputs at the falling edge, predict, then compare just after the rising edge.
  task automatic step(input logic st, input logic pr);
    exp_t e;
    @(negedge clk);
    start   = st;
    ped_req = pr;
    for (int i = 0; i < 2; i++) begin
      model_step(i, st, pr);
      sb.push_back('{inst: i, ph: 3'(m_state[i]), pnd: m_pend[i]});
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_inst(e);
    end
  endtask

  task automatic run_until(input state_e s, input int el, input string tag);
    int n;
    n = 0;
    while (!(m_state[0] == s && m_el[0] == el) && n < 200) begin
      step(1'b1, 1'b0);
      n++;
    end
    if (n >= 200) begin
      checks++;
      failures++;
      $error("FAIL %s observed=timeout expected=reached", tag);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s_phase[%0d]", tag, i), 32'(phase[i]), 32'(IDLE));
      chk($sformatf("%s_lamps[%0d]", tag, i),
          32'({ns_r[i], ns_y[i], ns_g[i], ew_r[i], ew_y[i], ew_g[i], walk[i]}),
          32'(7'b100_100_0));
      chk($sformatf("%s_pend[%0d]", tag, i), 32'(pend[i]), 32'd0);
    end
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // start low in IDLE: nothing moves
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Free run over two full 26-cycle periods, no pedestrian
    for (int k = 0; k < 56; k++) step(1'b1, 1'b0);

    // Single-cycle request during EW_G, then walk and return to NS_G
    run_until(EW_G, 2, "reach_ew_g");
    step(1'b1, 1'b1);
    for (int k = 0; k < 30; k++) step(1'b1, 1'b0);

    // Freeze for 4 cycles after the second NS_Y cycle
    run_until(NS_Y, 1, "reach_ns_y");
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0);
    for (int k = 0; k < 20; k++) step(1'b1, 1'b0);

    // Request level-high through AR2->WALK edge and during WALK
    for (int k = 0; k < 40; k++) step(1'b1, 1'b1);
    for (int k = 0; k < 10; k++) step(1'b1, 1'b0);

    // Asynchronous reset in the middle of EW_G
    run_until(EW_G, 3, "reach_ew_g_rst");
    @(negedge clk);
    start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
